// File: rtl/proj_mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
// Holds the write-buffer entry layout and the word-index extraction.
package proj_mem_pkg;

    localparam int WORD_W = 32;
    localparam int IDX_W  = WORD_W - 2;

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [WORD_W-1:0] data;
    } wbuf_entry_t;

    // Word index of a byte address, masked to the RAM's index width.
    function automatic logic [IDX_W-1:0] word_index(
        input logic [WORD_W-1:0] addr,
        input int unsigned       aw
    );
        logic [IDX_W-1:0] mask;
        mask = (IDX_W'(1) << aw) - IDX_W'(1);
        return addr[WORD_W-1:2] & mask;
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Circular posted-write buffer with a youngest-match lookup port.
// Lookup walks from the tail backwards so the newest store wins.
import proj_mem_pkg::*;

module wbuf_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wbuf_entry_t            push_entry,
    input  logic                   pop,
    output wbuf_entry_t            head_entry,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    input  logic [IDX_W-1:0]       lookup_index,
    output logic                   hit,
    output logic [WORD_W-1:0]      hit_data
);

    localparam int PW = $clog2(DEPTH);

    wbuf_entry_t   mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [PW-1:0] pos;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PW'(1);
            if (pop)  head_ptr <= head_ptr + PW'(1);
            if (push && !pop)
                count <= count + (PW+1)'(1);
            else if (pop && !push)
                count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= push_entry;
    end

    assign head_entry = mem[head_ptr];
    assign full       = (count == (PW+1)'(DEPTH));
    assign empty      = (count == '0);

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        pos      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = tail_ptr - PW'(k + 1);
            if (!hit && ((PW+1)'(k) < count)
                && (mem[pos].index == lookup_index)) begin
                hit      = 1'b1;
                hit_data = mem[pos].data;
            end
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// MEM-stage data memory: word RAM behind a posted write buffer,
// same-cycle loads with store forwarding, stall only on a full buffer.
import proj_mem_pkg::*;

module data_mem_resp #(
    parameter int RAM_WORDS  = 256,
    parameter int WBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] data_out,
    output logic        mem_stall,
    output logic        wbuf_empty,
    output logic        misalign_err
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(WBUF_DEPTH) + 1;

    logic [WORD_W-1:0] ram [RAM_WORDS];

    logic [IDX_W-1:0]  idx;
    logic              write_req;
    logic              idle;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              hit;
    logic [WORD_W-1:0] hit_data;
    logic              bad_access;
    logic              unused_idx;
    wbuf_entry_t       push_entry;
    wbuf_entry_t       head_entry;

    assign idx        = word_index(data_addr, AW);
    // A simultaneous read+write is served as a load only.
    assign write_req  = mem_write & ~mem_read;
    assign idle       = ~mem_read & ~mem_write;
    assign mem_stall  = write_req & (count == CW'(WBUF_DEPTH));
    assign push       = write_req & ~full;
    // RAM is single-port: drain only when no load or accepted store uses it.
    assign pop        = ~empty & (idle | mem_stall);
    assign push_entry = '{index: idx, data: data_in};
    assign wbuf_empty = empty;
    assign unused_idx = ^head_entry.index;

    wbuf_fifo #(
        .DEPTH(WBUF_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head_entry  (head_entry),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .lookup_index(idx),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    always_ff @(posedge clk) begin
        if (pop) ram[head_entry.index[AW-1:0]] <= head_entry.data;
    end

    assign bad_access = (mem_read & mem_write)
                      | ((mem_read | mem_write) & (data_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            misalign_err <= 1'b0;
        else if (bad_access)
            misalign_err <= 1'b1;
    end

    always_comb begin
        data_out = '0;
        if (mem_read)
            data_out = hit ? hit_data : ram[idx[AW-1:0]];
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed, table-driven bench for data_mem_resp.
// Vector table covers the main flow; reset and illegal cases are hand-written.
`timescale 1ns/100ps

module tb_data_mem_resp;

    logic        clk;
    logic        reset;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;
    logic        mem_stall;
    logic        wbuf_empty;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] dout;
        logic        stall;
        logic        empty;
        logic        mis;
    } vec_t;

    vec_t tbl[$];

    data_mem_resp #(
        .RAM_WORDS (256),
        .WBUF_DEPTH(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_addr   (data_addr),
        .data_in     (data_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .data_out    (data_out),
        .mem_stall   (mem_stall),
        .wbuf_empty  (wbuf_empty),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] din, input logic [31:0] dout,
                       input logic stall, input logic empty, input logic mis);
        tbl.push_back('{rd, wr, addr, din, dout, stall, empty, mis});
    endtask

    task automatic drive(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] din);
        mem_read  = rd;
        mem_write = wr;
        data_addr = addr;
        data_in   = din;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // forwarding then drain
        add(0, 1, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1, 0);
        add(1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 0);
        add(0, 0, 32'h10, 32'h0,        32'h0,        0, 0, 0);
        add(1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1, 0);
        // youngest match
        add(0, 1, 32'h20, 32'd1, 32'h0, 0, 1, 0);
        add(0, 1, 32'h20, 32'd2, 32'h0, 0, 0, 0);
        add(0, 1, 32'h20, 32'd3, 32'h0, 0, 0, 0);
        add(1, 0, 32'h20, 32'h0, 32'd3, 0, 0, 0);
        add(0, 0, 32'h0,  32'h0, 32'h0, 0, 0, 0);
        add(0, 0, 32'h0,  32'h0, 32'h0, 0, 0, 0);
        add(0, 0, 32'h0,  32'h0, 32'h0, 0, 0, 0);
        add(1, 0, 32'h20, 32'h0, 32'd3, 0, 1, 0);
        // full stall: fifth store stalls once
        add(0, 1, 32'h00, 32'hA0000000, 32'h0, 0, 1, 0);
        add(0, 1, 32'h04, 32'hA0000001, 32'h0, 0, 0, 0);
        add(0, 1, 32'h08, 32'hA0000002, 32'h0, 0, 0, 0);
        add(0, 1, 32'h0C, 32'hA0000003, 32'h0, 0, 0, 0);
        add(0, 1, 32'h10, 32'hA0000004, 32'h0, 1, 0, 0);
        add(0, 1, 32'h10, 32'hA0000004, 32'h0, 0, 0, 0);
        // ten loads on a full buffer never drain
        for (int r = 0; r < 2; r++) begin
            add(1, 0, 32'h00, 32'h0, 32'hA0000000, 0, 0, 0);
            add(1, 0, 32'h04, 32'h0, 32'hA0000001, 0, 0, 0);
            add(1, 0, 32'h08, 32'h0, 32'hA0000002, 0, 0, 0);
            add(1, 0, 32'h0C, 32'h0, 32'hA0000003, 0, 0, 0);
            add(1, 0, 32'h10, 32'h0, 32'hA0000004, 0, 0, 0);
        end
        // still full: next store stalls, then goes in
        add(0, 1, 32'h30, 32'hB0000000, 32'h0, 1, 0, 0);
        add(0, 1, 32'h30, 32'hB0000000, 32'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        add(1, 0, 32'h30, 32'h0, 32'hB0000000, 0, 1, 0);
        add(1, 0, 32'h04, 32'h0, 32'hA0000001, 0, 1, 0);
        // misaligned load returns word 0x10, flag sticks
        add(1, 0, 32'h13, 32'h0, 32'hA0000004, 0, 1, 0);
        add(0, 1, 32'h40, 32'hC0000000, 32'h0, 0, 1, 1);
        add(1, 0, 32'h40, 32'h0, 32'hC0000000, 0, 0, 1);
        add(0, 0, 32'h0,  32'h0, 32'h0, 0, 0, 1);
        add(1, 0, 32'h40, 32'h0, 32'hC0000000, 0, 1, 1);

        drive(0, 0, 32'h0, 32'h0);
        reset = 1'b0;
        #12;
        chk("reset_dout",  data_out,     32'h0);
        chk("reset_stall", 32'(mem_stall),    32'h0);
        chk("reset_empty", 32'(wbuf_empty),   32'h1);
        chk("reset_mis",   32'(misalign_err), 32'h0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
            #1;
            chk($sformatf("v%0d_dout", i),  data_out,             tbl[i].dout);
            chk($sformatf("v%0d_stall", i), 32'(mem_stall),       32'(tbl[i].stall));
            chk($sformatf("v%0d_empty", i), 32'(wbuf_empty),      32'(tbl[i].empty));
            chk($sformatf("v%0d_mis", i),   32'(misalign_err),    32'(tbl[i].mis));
            next_cycle();
        end

        // reset mid-operation with three stores pending
        drive(0, 1, 32'h00, 32'h11111111);
        next_cycle();
        drive(0, 1, 32'h04, 32'h22222222);
        next_cycle();
        drive(0, 1, 32'h08, 32'h33333333);
        #1;
        chk("pend_empty", 32'(wbuf_empty), 32'h0);
        next_cycle();
        drive(0, 1, 32'h0C, 32'h44444444);
        reset = 1'b0;
        #1;
        chk("rst_mid_empty", 32'(wbuf_empty),   32'h1);
        chk("rst_mid_stall", 32'(mem_stall),    32'h0);
        chk("rst_mid_mis",   32'(misalign_err), 32'h0);
        drive(0, 0, 32'h0, 32'h0);
        #1;
        reset = 1'b1;
        next_cycle();
        drive(1, 0, 32'h00, 32'h0);
        #1;
        chk("post_rst_0", data_out, 32'hA0000000);
        next_cycle();
        drive(1, 0, 32'h04, 32'h0);
        #1;
        chk("post_rst_4", data_out, 32'hA0000001);
        next_cycle();
        drive(1, 0, 32'h08, 32'h0);
        #1;
        chk("post_rst_8", data_out, 32'hA0000002);
        chk("post_rst_empty", 32'(wbuf_empty), 32'h1);
        next_cycle();

        // read+write together: load only, flags error, nothing enqueued
        drive(1, 1, 32'h00, 32'h55555555);
        #1;
        chk("illegal_dout", data_out, 32'hA0000000);
        next_cycle();
        drive(1, 0, 32'h00, 32'h0);
        #1;
        chk("illegal_mis",   32'(misalign_err), 32'h1);
        chk("illegal_empty", 32'(wbuf_empty),   32'h1);
        chk("illegal_dout2", data_out,          32'hA0000000);
        next_cycle();
        drive(0, 0, 32'h0, 32'h0);
        #1;
        chk("idle_dout", data_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
